// File: rtl/ram_sp_bidir.sv
// ram_sp_bidir: single-port synchronous RAM with a shared bidirectional data bus.
// After reset, an init sweep writes CLR_VAL into every word while busy is high.
// After the sweep, accesses are qualified by ce. A write is taken when we=1.
// A read is taken when we=0 and returns one cycle later with an rd_valid strobe.
// Optional feature macro: RAM_PARITY_EN.
//   When it is defined, each word carries an even-parity bit.
//   perr flags a mismatch on read return.
//
// state   | meaning
// S_INIT  | clearing mem[clr_cnt] to CLR_VAL, accesses ignored, busy=1
// S_READY | normal read/write service
module ram_sp_bidir #(
    parameter int             DW      = 8,
    parameter int             DEPTH   = 16,
    parameter int             AW      = 4,
    parameter logic [DW-1:0]  CLR_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic          we,
    input  logic [AW-1:0] addr,
    inout  wire  [DW-1:0] data,
    output logic          rd_valid,
    output logic          busy,
    output logic          perr
);

`ifdef RAM_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif

    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   clr_cnt;
    logic [MW-1:0]   mem [DEPTH];
    logic [DW-1:0]   rdata_q;
    logic [MW-1:0]   rd_word;
    logic            in_range;
    logic            wr_en;
    logic            rd_en;

    // Stored word: data, with the even-parity bit on top when parity is enabled.
    function automatic logic [MW-1:0] enc(input logic [DW-1:0] d);
`ifdef RAM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    assign in_range = ({1'b0, addr} < DEPTH_L);
    assign rd_word  = in_range ? mem[addr] : '0;

    // The RAM drives the bus only in the read-return cycle, and a concurrent write takes the bus.
    assign data = (rd_valid && !we) ? rdata_q : 'z;

    // State register: reset always restarts the init sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_INIT;
        else        state <= state_nxt;
    end

    // Next state: leave INIT on the edge that writes the last word.
    always_comb begin
        state_nxt = state;
        if (state == S_INIT && clr_cnt == LAST) state_nxt = S_READY;
    end

    // Outputs and access qualifiers derived from the current state.
    always_comb begin
        busy  = (state == S_INIT);
        wr_en = (state == S_READY) && ce && we && in_range;
        rd_en = (state == S_READY) && ce && !we;
    end

    // Clear counter: it walks 0..DEPTH-1 during INIT and then holds until the next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       clr_cnt <= '0;
        else if (busy && clr_cnt != LAST) clr_cnt <= clr_cnt + 1'b1;
    end

    // Storage array has no reset, so it infers as plain memory; the init sweep clears it.
    always_ff @(posedge clk) begin
        if (busy)       mem[clr_cnt] <= enc(CLR_VAL);
        else if (wr_en) mem[addr]    <= enc(data);
    end

    // Registered read return. An out-of-range read returns zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rdata_q <= rd_word[DW-1:0];
        end
    end

`ifdef RAM_PARITY_EN
    logic perr_q;

    // Parity check on the word being read. It is cleared when no read is returning.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     perr_q <= 1'b0;
        else if (rd_en) perr_q <= in_range && ((^rd_word[DW-1:0]) != rd_word[DW]);
        else            perr_q <= 1'b0;
    end

    assign perr = perr_q;
`else
    assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_ram_sp_bidir.sv
// Bench for ram_sp_bidir.
// Two instances share one stimulus stream: instance 0 has DEPTH=16 and instance 1 has DEPTH=12, so out-of-range behaviour is covered.
// A word-array reference model predicts every output cycle by cycle.
module tb_ram_sp_bidir;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce, we;
    logic [3:0] addr;
    logic       drv_en;
    logic [7:0] drv_val;
    wire  [7:0] data_a, data_b;
    logic       rv_a, rv_b, busy_a, busy_b, perr_a, perr_b;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem_m  [2][16];
    bit         cor_m  [2][16];
    int         busy_m [2];
    bit         rv_m   [2];
    bit         pe_m   [2];
    logic [7:0] rd_m   [2];
    int         depth_m[2] = '{16, 12};

    always #5 clk = ~clk;

    assign data_a = drv_en ? drv_val : 'z;
    assign data_b = drv_en ? drv_val : 'z;

    ram_sp_bidir #(.DW(8), .DEPTH(16), .AW(4), .CLR_VAL(8'hA5)) dut_a (
        .clk(clk), .rst_n(rst_n), .ce(ce), .we(we), .addr(addr), .data(data_a),
        .rd_valid(rv_a), .busy(busy_a), .perr(perr_a));

    ram_sp_bidir #(.DW(8), .DEPTH(12), .AW(4), .CLR_VAL(8'hA5)) dut_b (
        .clk(clk), .rst_n(rst_n), .ce(ce), .we(we), .addr(addr), .data(data_b),
        .rd_valid(rv_b), .busy(busy_b), .perr(perr_b));

    function automatic logic [7:0] obs_data(input int i);
        return (i == 0) ? data_a : data_b;
    endfunction
    function automatic logic obs_rv(input int i);
        return (i == 0) ? rv_a : rv_b;
    endfunction
    function automatic logic obs_busy(input int i);
        return (i == 0) ? busy_a : busy_b;
    endfunction
    function automatic logic obs_perr(input int i);
        return (i == 0) ? perr_a : perr_b;
    endfunction

    task automatic chk(input string tag, input int inst, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, inst, obs, exp);
        end
    endtask

    // After reset: every word holds CLR_VAL, the sweep takes DEPTH cycles, and no read is pending.
    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            busy_m[i] = depth_m[i];
            rv_m[i]   = 1'b0;
            pe_m[i]   = 1'b0;
            rd_m[i]   = 8'h00;
            for (int k = 0; k < 16; k++) begin
                mem_m[i][k] = 8'hA5;
                cor_m[i][k] = 1'b0;
            end
        end
    endtask

    // One bus cycle: apply inputs at the negedge, check outputs, then advance the model over the next posedge.
    task automatic step(input bit c, input bit w, input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        ce = c; we = w; addr = a; drv_en = c && w; drv_val = d;
        #1;
        for (int i = 0; i < 2; i++) begin
            logic [7:0] ed;
            if (rv_m[i] && !w) ed = rd_m[i];
            else if (c && w)   ed = d;
            else               ed = 'z;
            chk("rd_valid", i, {7'b0, obs_rv(i)},   {7'b0, rv_m[i]});
            chk("busy",     i, {7'b0, obs_busy(i)}, {7'b0, busy_m[i] > 0});
            chk("perr",     i, {7'b0, obs_perr(i)}, {7'b0, rv_m[i] && pe_m[i]});
            chk("data",     i, obs_data(i), ed);
        end
        for (int i = 0; i < 2; i++) begin
            if (busy_m[i] > 0) begin
                busy_m[i]--;
                rv_m[i] = 1'b0;
            end else if (c && w) begin
                if (int'(a) < depth_m[i]) begin
                    mem_m[i][a] = d;
                    cor_m[i][a] = 1'b0;
                end
                rv_m[i] = 1'b0;
            end else if (c) begin
                rv_m[i] = 1'b1;
                rd_m[i] = (int'(a) < depth_m[i]) ? mem_m[i][a] : 8'h00;
                pe_m[i] = (int'(a) < depth_m[i]) ? cor_m[i][a] : 1'b0;
            end else begin
                rv_m[i] = 1'b0;
            end
        end
    endtask

    task automatic check_in_reset();
        for (int i = 0; i < 2; i++) begin
            chk("rst_rd_valid", i, {7'b0, obs_rv(i)},   8'h00);
            chk("rst_busy",     i, {7'b0, obs_busy(i)}, 8'h01);
            chk("rst_perr",     i, {7'b0, obs_perr(i)}, 8'h00);
            chk("rst_data",     i, obs_data(i),         8'hzz);
        end
    endtask

    initial begin
        rst_n = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; drv_en = 1'b0; drv_val = '0;
        #1 rst_n = 1'b0;
        #2 check_in_reset();
        @(posedge clk); #2 rst_n = 1'b1;
        reset_model();

        // Accesses during the sweep are ignored; idle until both sweeps are done.
        step(1, 1, 4'd2, 8'hFF);
        step(1, 0, 4'd2, 8'h00);
        for (int k = 0; k < 15; k++) step(0, 0, 4'd0, 8'h00);

        // Read back every address, back to back.
        for (int k = 0; k < 16; k++) step(1, 0, 4'(k), 8'h00);
        step(0, 0, 4'd0, 8'h00);

        // Write then read, including read-after-write on the next cycle.
        step(1, 1, 4'd7, 8'h3C);
        step(1, 0, 4'd7, 8'h00);
        step(0, 0, 4'd0, 8'h00);
        step(0, 0, 4'd0, 8'h00);

        // Bus turnaround: a write directly after a read takes the bus.
        step(1, 1, 4'd3, 8'h11);
        step(1, 0, 4'd3, 8'h00);
        step(1, 1, 4'd5, 8'h22);
        step(1, 0, 4'd5, 8'h00);
        step(0, 0, 4'd0, 8'h00);

        // Address 13 is in range for the 16-word instance and out of range for the 12-word one.
        step(1, 1, 4'd13, 8'h55);
        step(1, 0, 4'd13, 8'h00);
        step(0, 0, 4'd0, 8'h00);

        for (int k = 0; k < 250; k++)
            step($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), 8'($urandom));
        step(0, 0, 4'd0, 8'h00);

`ifdef RAM_PARITY_EN
        step(1, 1, 4'd0, 8'h01);
        step(0, 0, 4'd0, 8'h00);
        dut_a.mem[0][8] = ~dut_a.mem[0][8];
        dut_b.mem[0][8] = ~dut_b.mem[0][8];
        cor_m[0][0] = 1'b1;
        cor_m[1][0] = 1'b1;
        step(1, 0, 4'd0, 8'h00);
        step(1, 0, 4'd9, 8'h00);
        step(0, 0, 4'd0, 8'h00);
`endif

        // Reset while rd_valid is high: the strobe and the bus must drop at once.
        step(1, 0, 4'd7, 8'h00);
        @(posedge clk); #2;
        for (int i = 0; i < 2; i++) begin
            chk("pre_rst_rd_valid", i, {7'b0, obs_rv(i)}, {7'b0, rv_m[i]});
            chk("pre_rst_data",     i, obs_data(i),       rd_m[i]);
        end
        rst_n = 1'b0;
        #1 check_in_reset();
        @(posedge clk); #2 rst_n = 1'b1;
        reset_model();
        for (int k = 0; k < 16; k++) step(0, 0, 4'd0, 8'h00);
        for (int k = 0; k < 16; k++) step(1, 0, 4'(k), 8'h00);
        step(0, 0, 4'd0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_sp_bidir.md
Name: ram_sp_bidir

Overview:
- Parametrised single-port synchronous RAM with a shared bidirectional data bus.
- Next generation of the team's 16x8 bidirectional RAM: configurable width and depth, chip enable, registered read with a valid strobe, and a post-reset clear state machine.
- Sits behind a simple bus master (CPU-lab datapath or testbench driver) that owns the address, we and ce signals.

Parameters:
DW, 8, data word width in bits
DEPTH, 16, number of words; DEPTH <= 2**AW required
AW, 4, address width in bits
CLR_VAL, 0, DW-bit value written to every word during the init sweep

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
ce  input  1  chip enable; no access when 0
we  input  1  1 = write cycle, 0 = read cycle (qualified by ce)
addr  input  AW  word address
data  inout  DW  bidirectional data bus; RAM drives only in the read-return cycle
rd_valid  output  1  one-cycle strobe; data carries read result this cycle
busy  output  1  1 while the init sweep runs; accesses ignored
perr  output  1  parity error on the current read return (0 when feature absent)

Behaviour:
- Reset (async, rst_n=0):
  - rd_valid=0, perr=0, busy=1.
  - data released to Z immediately.
  - FSM enters INIT with clear counter clr_cnt=0.
- FSM states: INIT -> READY.
  - INIT: each cycle writes CLR_VAL to mem[clr_cnt], then clr_cnt++.
  - When clr_cnt==DEPTH-1 is written, the next state is READY and busy drops to 0 on that edge.
  - INIT lasts exactly DEPTH cycles after the first rising edge with rst_n=1.
- READY:
  - Write: ce=1, we=1 at posedge -> mem[addr] <= data. No rd_valid.
  - Read: ce=1, we=0 at posedge -> rdata_q <= mem[addr]; rd_valid=1 in the following cycle only.
  - Read latency: 1 cycle. Back-to-back reads give one strobe per cycle.
- Bus drive:
  - data = rdata_q when (rd_valid && !we), else Z.
  - A write issued in the cycle after a read wins: RAM releases the bus combinationally when we=1.
  - The read result is lost in that case, but rd_valid still pulses.
- Read-after-write: a read of the same address in the next cycle returns the newly written value.
- ce=0: no access; rd_valid=0 next cycle.
- Accesses while busy=1 are ignored: no write, no rd_valid, bus never driven.
- Out-of-range address (addr >= DEPTH, possible when DEPTH < 2**AW):
  - Write is dropped.
  - Read returns all-zeros with rd_valid=1 and perr=0.
- Reset mid-operation:
  - Any pending rd_valid is cancelled and the bus goes Z at once.
  - The init sweep restarts from 0, so contents are re-cleared to CLR_VAL.
- Storage is inferable as a register array; no read-during-write combinational path.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - Each word stores DW+1 bits: data plus even parity (XOR of data bits).
  - Parity is computed on every write, including the init sweep.
  - On read return, perr=1 in the same cycle as rd_valid if the recomputed parity of the stored data mismatches the stored bit; otherwise 0.
  - A hierarchical-access task/force path on the parity bit lets the bench corrupt a word.
- Undefined: storage is DW bits wide and perr is tied to 0.

Test Plan:
- Init sweep: DW=8, DEPTH=16, CLR_VAL=8'hA5; release rst_n, then read all 16 addresses after busy falls -> busy high for exactly 16 cycles, every read returns 8'hA5 one cycle after the request with rd_valid=1.
- Write/read: write 8'h3C to addr 4'h7, then read addr 4'h7 next cycle -> data=8'h3C driven only in the rd_valid cycle, Z before and after.
- Access during busy: during INIT, write 8'hFF to addr 2 and issue a read of addr 2 -> no rd_valid, data stays Z; after READY, read addr 2 returns CLR_VAL.
- Bus turnaround: read addr 3 (holding 8'h11), then write 8'h22 to addr 5 in the next cycle -> RAM leaves data undriven during the write, no contention (X), addr 5 reads back 8'h22.
- Out-of-range and reset: DEPTH=12, AW=4; write 8'h55 to addr 13 -> read of 13 returns 8'h00. Assert rst_n=0 in the cycle rd_valid is high -> rd_valid and data (to Z) drop immediately and the init sweep restarts.
- Parity (RAM_PARITY_EN): write 8'h01 to addr 0, flip its stored parity bit, read addr 0 -> rd_valid=1, perr=1; read of an untouched address gives perr=0.
